// File: rtl/alu_ctrl_pkg.sv
// Shared decode constants and FSM state type for the ALU control block.
package alu_ctrl_pkg;

    localparam logic [2:0] RTYPE_OP = 3'b011;

    localparam logic [2:0] FUNC_AND = 3'b000;
    localparam logic [2:0] FUNC_ADD = 3'b001;
    localparam logic [2:0] FUNC_SUB = 3'b010;
    localparam logic [2:0] FUNC_XOR = 3'b011;
    localparam logic [2:0] FUNC_OR  = 3'b101;
    localparam logic [2:0] FUNC_MUL = 3'b110;

    localparam logic [2:0] SEL_AND = 3'b110;
    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SUB = 3'b010;
    localparam logic [2:0] SEL_XOR = 3'b001;
    localparam logic [2:0] SEL_OR  = 3'b111;
    localparam logic [2:0] SEL_DEF = 3'b100;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_control_mc_if.sv
// Request/result bus between decode stage, ALU control and writeback.
interface alu_control_mc_if #(parameter int DATA_W = 32);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        func;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              out_valid;
    logic [2:0]        sel;
    logic              is_mul;
    logic [DATA_W-1:0] prod_hi;
    logic [DATA_W-1:0] prod_lo;

    modport master (
        output in_valid, func, alu_op, op_a, op_b,
        input  in_ready, out_valid, sel, is_mul, prod_hi, prod_lo
    );

    modport slave (
        input  in_valid, func, alu_op, op_a, op_b,
        output in_ready, out_valid, sel, is_mul, prod_hi, prod_lo
    );
endinterface

// File: rtl/alu_sel_decode.sv
// Combinational func/alu_op to ALU select decode; shared with the single-cycle datapath.
module alu_sel_decode
    import alu_ctrl_pkg::*;
(
    input  logic [2:0] func,
    input  logic [2:0] alu_op,
    output logic [2:0] sel,
    output logic       is_mul_op
);

    always_comb begin
        sel       = alu_op;
        is_mul_op = 1'b0;
        if (alu_op == RTYPE_OP) begin
            case (func)
                FUNC_AND: sel = SEL_AND;
                FUNC_ADD: sel = SEL_ADD;
                FUNC_SUB: sel = SEL_SUB;
                FUNC_XOR: sel = SEL_XOR;
                FUNC_OR:  sel = SEL_OR;
                FUNC_MUL: begin
                    sel       = SEL_ADD;
                    is_mul_op = 1'b1;
                end
                default:  sel = SEL_DEF;
            endcase
        end
    end

endmodule

// File: rtl/alu_control_mc.sv
// Registered ALU select decode plus an iterative shift-add unsigned multiplier.
module alu_control_mc
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_control_mc_if.slave          bus
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic                out_valid_q, out_valid_d;
    logic [2:0]          sel_q, sel_d;
    logic                is_mul_q, is_mul_d;
    logic [DATA_W-1:0]   prod_hi_q, prod_hi_d;
    logic [DATA_W-1:0]   prod_lo_q, prod_lo_d;

    logic [2:0]          dec_sel;
    logic                dec_is_mul;
    logic                accept;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] shifted;

    alu_sel_decode u_dec (
        .func      (bus.func),
        .alu_op    (bus.alu_op),
        .sel       (dec_sel),
        .is_mul_op (dec_is_mul)
    );

    assign bus.in_ready  = (state_q != MUL_RUN);
    assign accept        = bus.in_valid && bus.in_ready;

    // Carry out of the partial add becomes the top bit shifted into hi.
    assign sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(DATA_W+1){1'b0}});
    assign shifted = {sum, lo_q[DATA_W-1:1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mcand_d     = mcand_q;
        out_valid_d = 1'b0;
        sel_d       = sel_q;
        is_mul_d    = is_mul_q;
        prod_hi_d   = prod_hi_q;
        prod_lo_d   = prod_lo_q;

        case (state_q)
            MUL_RUN: begin
                hi_d  = shifted[2*DATA_W-1:DATA_W];
                lo_d  = shifted[DATA_W-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = MUL_DONE;
                    out_valid_d = 1'b1;
                    is_mul_d    = 1'b1;
                    sel_d       = SEL_ADD;
                    prod_hi_d   = shifted[2*DATA_W-1:DATA_W];
                    prod_lo_d   = shifted[DATA_W-1:0];
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    if (dec_is_mul) begin
                        mcand_d = bus.op_a;
                        hi_d    = '0;
                        lo_d    = bus.op_b;
                        cnt_d   = CNT_W'(DATA_W);
                        state_d = MUL_RUN;
                    end else begin
                        out_valid_d = 1'b1;
                        sel_d       = dec_sel;
                        is_mul_d    = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            mcand_q     <= '0;
            out_valid_q <= 1'b0;
            sel_q       <= 3'b000;
            is_mul_q    <= 1'b0;
            prod_hi_q   <= '0;
            prod_lo_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mcand_q     <= mcand_d;
            out_valid_q <= out_valid_d;
            sel_q       <= sel_d;
            is_mul_q    <= is_mul_d;
            prod_hi_q   <= prod_hi_d;
            prod_lo_q   <= prod_lo_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sel       = sel_q;
    assign bus.is_mul    = is_mul_q;
    assign bus.prod_hi   = prod_hi_q;
    assign bus.prod_lo   = prod_lo_q;

endmodule
